// File: rtl/event_serializer.sv
// Event serializer: FIFO of {x,y,t} tuples drained as 7-byte frames
// (A5, x, y, t big-endian) over a valid/ready byte stream.
// Ports: clk, rst (sync, active-high); x, y, t, p, in_valid (event in);
//   out_data, out_valid, out_ready (byte stream out);
//   fifo_full, fifo_count, ovf_count, busy (status).
module event_serializer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              x,
  input  logic [15:0]              y,
  input  logic [15:0]              t,
  input  logic                     p,
  input  logic                     in_valid,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     fifo_full,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               ovf_count,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  logic [47:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  state_t        state;
  logic [47:0]   frame;
  logic [2:0]    idx;

  logic empty;
  logic last;
  logic pop;
  logic push_req;
  logic push;
  logic drop;

  assign empty     = (fifo_count == '0);
  assign fifo_full = (fifo_count == (AW+1)'(DEPTH));
  assign last      = (state == SEND) && out_ready && (idx == 3'd6);
  // Refill on the edge the final byte leaves, so frames run back-to-back.
  assign pop       = !empty && ((state == IDLE) || last);
  assign push_req  = in_valid && p;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push      = push_req && (!fifo_full || pop);
  assign drop      = push_req && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (!rst && push)
      mem[wr_ptr] <= {x, y, t};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      ovf_count  <= 8'h00;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (drop && ovf_count != 8'hFF)
        ovf_count <= ovf_count + 8'h01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      frame <= '0;
      idx   <= 3'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            state <= SEND;
            frame <= mem[rd_ptr];
            idx   <= 3'd0;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (idx == 3'd6) begin
              idx <= 3'd0;
              if (pop)
                frame <= mem[rd_ptr];
              else
                state <= IDLE;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid = (state == SEND);
  assign busy      = (state == SEND);

  always_comb begin
    out_data = 8'h00;
    if (state == SEND) begin
      unique case (idx)
        3'd0:    out_data = 8'hA5;
        3'd1:    out_data = frame[47:40];
        3'd2:    out_data = frame[39:32];
        3'd3:    out_data = frame[31:24];
        3'd4:    out_data = frame[23:16];
        3'd5:    out_data = frame[15:8];
        3'd6:    out_data = frame[7:0];
        default: out_data = 8'h00;
      endcase
    end
  end

endmodule

// File: doc/event_serializer.md
EVENT_SERIALIZER -- requirements
Module: event_serializer

Interface
REQ-001 Parameter: DEPTH, default 4, number of event entries in the FIFO (power of two, 2..16).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 x  input  16  filtered event x coordinate.
REQ-005 y  input  16  filtered event y coordinate.
REQ-006 t  input  16  filtered event timestamp.
REQ-007 p  input  1  filtered polarity; 1 marks a live event, 0 marks a zeroed tuple.
REQ-008 in_valid  input  1  upstream tuple present this cycle.
REQ-009 out_data  output  8  current serial byte.
REQ-010 out_valid  output  1  out_data holds a valid byte.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 fifo_full  output  1  FIFO holds DEPTH entries.
REQ-013 fifo_count  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-014 ovf_count  output  8  events lost to a full FIFO, saturating.
REQ-015 busy  output  1  serializer is mid-frame.

Function
REQ-016 Push condition: in_valid=1 and p=1; {x,y,t} written to the FIFO tail on that edge.
REQ-017 in_valid=1 with p=0 is ignored: no write and no counter change.
REQ-018 No upstream backpressure: a push while the FIFO is full and no pop occurs that cycle drops the event and increments ovf_count.
REQ-019 ovf_count saturates at 255.
REQ-020 Frame is 7 bytes in order: 0xA5, x[15:8], x[7:0], y[15:8], y[7:0], t[15:8], t[7:0].
REQ-021 Serializer has two states: IDLE (busy=0, out_valid=0) and SEND (busy=1, out_valid=1) with a byte index 0..6.
REQ-022 IDLE -> SEND: on an edge where the FIFO is non-empty, the head entry is popped into a 48-bit frame register and the index is set to 0.
REQ-023 Latency: an event pushed into an empty FIFO with the serializer IDLE gives out_valid=1 with byte 0xA5 one cycle after the push edge.
REQ-024 A byte transfers on an edge with out_valid=1 and out_ready=1; the index then advances by 1.
REQ-025 While out_valid=1 and out_ready=0, out_data and the index hold stable.
REQ-026 Transfer of byte 6 with the FIFO non-empty pops the next entry on the same edge and restarts at index 0, with no idle cycle between frames.
REQ-027 Transfer of byte 6 with the FIFO empty returns the block to IDLE.
REQ-028 Simultaneous push and pop on one edge: both take effect and fifo_count is unchanged.
REQ-029 A push to a full FIFO on a pop edge is accepted, not dropped.
REQ-030 Read and write pointers wrap modulo DEPTH; fifo_full = (fifo_count == DEPTH).
REQ-031 out_data = 0x00 whenever out_valid=0.

Reset
REQ-032 rst=1 at a clock edge clears the pointers, sets fifo_count=0, fifo_full=0, ovf_count=0, enters IDLE, and sets out_valid=0, busy=0, out_data=0x00.
REQ-033 Reset mid-frame aborts the frame; no partial byte sequence resumes after reset.
REQ-034 Reset takes priority over a push or a handshake in the same cycle.

Verification
REQ-035 Single event: push x=0x1234, y=0xABCD, t=0x0F0F, p=1, out_ready=1 held -> bytes A5,12,34,AB,CD,0F,0F on 7 consecutive cycles starting one cycle after the push; then busy=0.
REQ-036 Polarity drop: in_valid=1, p=0, arbitrary x/y/t -> fifo_count stays 0, out_valid stays 0, ovf_count stays 0.
REQ-037 Backpressure: out_ready=0 for 5 cycles during byte 2 -> out_data holds x[7:0] stable; the sequence resumes intact when out_ready=1.
REQ-038 Overflow: out_ready=0, push DEPTH+2 events (DEPTH=4; entry 1 is popped into the frame register) -> fifo_count=4, fifo_full=1, ovf_count=1; 256 further pushes -> ovf_count=255.
REQ-039 Back-to-back: 3 queued events with out_ready=1 -> 21 contiguous valid bytes with 0xA5 at byte offsets 0, 7 and 14, and no bubble.
REQ-040 Mid-frame reset: assert rst during byte 3 of a frame with 2 entries queued -> next cycle out_valid=0, fifo_count=0, ovf_count=0, and no residual bytes appear afterwards.
